// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the system reset.
// Build macro PLL_RESET_SEQ_AUTORETRY_EN: re-pulse the PLL after every lock timeout.
module pll_reset_sequencer #(
  parameter int in_hz               = 25000000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 250000,
  parameter int STABLE_CYCLES       = 2500,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       locked_i,
  input  logic       sw_rst_i,
  output logic       pll_rst_o,
  output logic       rst_o,
  output logic       ready_o,
  output logic [1:0] state_o,
  output logic [7:0] loss_cnt_o,
  output logic       timeout_o
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  if (in_hz < 1 || PLL_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
    $error("pll_reset_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  // locked_i comes straight from the PLL, so it only enters the FSM through this chain
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign state_o  = state;

  // One shared counter serves the pulse length, the lock timeout and the stability window
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state      <= PLL_RST;
      cnt        <= '0;
      pll_rst_o  <= 1'b1;
      rst_o      <= 1'b1;
      ready_o    <= 1'b0;
      loss_cnt_o <= '0;
      timeout_o  <= 1'b0;
    end else if (sw_rst_i) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_rst_o <= 1'b1;
      rst_o     <= 1'b1;
      ready_o   <= 1'b0;
    end else begin
      case (state)
        PLL_RST: begin
          if (cnt == PLL_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_rst_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            timeout_o <= 1'b1;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
            state     <= PLL_RST;
            cnt       <= '0;
            pll_rst_o <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          // Any dropout restarts the wait, which also gives the timeout a fresh window
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            rst_o   <= 1'b0;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_rst_o <= 1'b1;
            rst_o     <= 1'b1;
            ready_o   <= 1'b0;
            if (loss_cnt_o != 8'hFF) begin
              loss_cnt_o <= loss_cnt_o + 8'd1;
            end
          end
        end
        default: begin
          state <= PLL_RST;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table, corner-case sequences and
// randomized lock/sw-reset stimulus against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 20;
  localparam int STABLE_CYCLES       = 8;
  localparam int SYNC_STAGES         = 2;

  logic       clk_i = 1'b0;
  logic       reset;
  logic       locked_i;
  logic       sw_rst_i;
  logic       pll_rst_o;
  logic       rst_o;
  logic       ready_o;
  logic [1:0] state_o;
  logic [7:0] loss_cnt_o;
  logic       timeout_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: current phase, cycles completed in it, and the raw lock history
  int m_phase;
  int m_elapsed;
  int m_loss;
  bit m_timeout;
  bit m_hist[$];

  typedef struct {
    bit       lk;
    bit       sw;
    bit [1:0] st;
    bit       pll;
    bit       rst;
    bit       rdy;
  } vec_t;

  vec_t tbl[15];

  pll_reset_sequencer #(
    .in_hz              (25000000),
    .PLL_RST_CYCLES     (PLL_RST_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .STABLE_CYCLES      (STABLE_CYCLES),
    .SYNC_STAGES        (SYNC_STAGES)
  ) dut (
    .clk_i     (clk_i),
    .reset     (reset),
    .locked_i  (locked_i),
    .sw_rst_i  (sw_rst_i),
    .pll_rst_o (pll_rst_o),
    .rst_o     (rst_o),
    .ready_o   (ready_o),
    .state_o   (state_o),
    .loss_cnt_o(loss_cnt_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_phase   = 0;
    m_elapsed = 0;
    m_loss    = 0;
    m_timeout = 1'b0;
    m_hist    = {};
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
  endtask

  task automatic modelEdge(input bit lk, input bit sw);
    bit ls;
    ls = m_hist[0];
    m_hist.push_back(lk);
    m_hist.delete(0);
    if (sw) begin
      m_phase   = 0;
      m_elapsed = 0;
    end else begin
      case (m_phase)
        0: begin
          m_elapsed++;
          if (m_elapsed == PLL_RST_CYCLES) begin
            m_phase   = 1;
            m_elapsed = 0;
          end
        end
        1: begin
          if (ls) begin
            m_phase   = 2;
            m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed >= LOCK_TIMEOUT_CYCLES) begin
              m_timeout = 1'b1;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
              m_phase   = 0;
              m_elapsed = 0;
`else
              m_elapsed = LOCK_TIMEOUT_CYCLES;
`endif
            end
          end
        end
        2: begin
          if (!ls) begin
            m_phase   = 1;
            m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == STABLE_CYCLES) begin
              m_phase   = 3;
              m_elapsed = 0;
            end
          end
        end
        default: begin
          if (!ls) begin
            m_loss    = (m_loss < 255) ? m_loss + 1 : 255;
            m_phase   = 0;
            m_elapsed = 0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [13:0] dutVec();
    return {state_o, pll_rst_o, rst_o, ready_o, loss_cnt_o, timeout_o};
  endfunction

  function automatic logic [13:0] modelVec();
    return {2'(m_phase), m_phase == 0, m_phase != 3, m_phase == 3, 8'(m_loss), m_timeout};
  endfunction

  // Drives one cycle of inputs, advances the model on the edge, compares mid-cycle
  task automatic applyStimulus(input bit lk, input bit sw);
    locked_i = lk;
    sw_rst_i = sw;
    @(posedge clk_i);
    modelEdge(lk, sw);
    #1;
    checkOutput("model", 32'(dutVec()), 32'(modelVec()));
  endtask

  task automatic runUntilReady(input string name, input int bound);
    for (int i = 0; i < bound && ready_o !== 1'b1; i++) applyStimulus(1'b1, 1'b0);
    checkOutput(name, 32'(ready_o), 32'd1);
  endtask

  task automatic dropUntilReset(input string name, input int bound);
    int e;
    e = 0;
    while (rst_o !== 1'b1 && e < bound) begin
      applyStimulus(1'b0, 1'b0);
      e++;
    end
    checkOutput(name, 32'(rst_o), 32'd1);
  endtask

  initial begin
    int  cyc;
    int  edges;
    int  n;
    int  errs;
    bit  saw_wait;
    bit  rst_held;
    bit  hold_ok;
    bit  lk;
    int  seg_left;

    for (int c = 0; c < 15; c++) begin
      tbl[c].lk  = 1'b1;
      tbl[c].sw  = 1'b0;
      tbl[c].st  = (c < 4) ? 2'd0 : (c == 4) ? 2'd1 : (c < 13) ? 2'd2 : 2'd3;
      tbl[c].pll = (c < 4);
      tbl[c].rst = (c < 13);
      tbl[c].rdy = (c >= 13);
    end

    locked_i = 1'b1;
    sw_rst_i = 1'b0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_state", 32'(dutVec()), 32'({2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0}));
    @(posedge clk_i);
    #1 reset = 1'b0;
    modelReset();

    $display("[TB] clean start vector table");
    for (int c = 0; c < 15; c++) begin
      checkOutput($sformatf("clean_start_c%0d", c),
                  32'({state_o, pll_rst_o, rst_o, ready_o}),
                  32'({tbl[c].st, tbl[c].pll, tbl[c].rst, tbl[c].rdy}));
      applyStimulus(tbl[c].lk, tbl[c].sw);
    end

    $display("[TB] one-cycle lock glitch in STABLE");
    reset = 1'b1;
    #1 reset = 1'b0;
    modelReset();
    for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0);
    checkOutput("glitch_in_stable", 32'(state_o), 32'd2);
    applyStimulus(1'b0, 1'b0);
    cyc      = 8;
    saw_wait = 1'b0;
    rst_held = 1'b1;
    for (int i = 0; i < 40 && ready_o !== 1'b1; i++) begin
      if (state_o == 2'd1) saw_wait = 1'b1;
      if (rst_o !== 1'b1) rst_held = 1'b0;
      applyStimulus(1'b1, 1'b0);
      cyc++;
    end
    checkOutput("glitch_saw_wait", 32'(saw_wait), 32'd1);
    checkOutput("glitch_rst_held", 32'(rst_held), 32'd1);
    checkOutput("glitch_release_cycle", 32'(cyc), 32'd19);

    $display("[TB] lock loss in RUN");
    edges = 0;
    while (rst_o !== 1'b1 && edges < 10) begin
      applyStimulus(1'b0, 1'b0);
      edges++;
    end
    checkOutput("loss_latency", 32'(edges), 32'(SYNC_STAGES + 1));
    checkOutput("loss_count_1", 32'(loss_cnt_o), 32'd1);
    n = 0;
    while (pll_rst_o === 1'b1 && n < 10) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("loss_pll_pulse", 32'(n), 32'(PLL_RST_CYCLES));

    $display("[TB] sw reset coincident with lock loss");
    runUntilReady("sw_prep_ready", 60);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (state_o !== 2'd0 || pll_rst_o !== 1'b1 || rst_o !== 1'b1) hold_ok = 1'b0;
    end
    checkOutput("sw_hold", 32'(hold_ok), 32'd1);
    checkOutput("sw_no_loss", 32'(loss_cnt_o), 32'd1);
    n = 0;
    while (pll_rst_o === 1'b1 && n < 10) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("sw_release_pulse", 32'(n), 32'(PLL_RST_CYCLES));

    $display("[TB] 300 lock losses");
    for (int k = 0; k < 300; k++) begin
      runUntilReady("loss_loop_ready", 60);
      dropUntilReset("loss_loop_rst", 10);
    end
    checkOutput("loss_saturate", 32'(loss_cnt_o), 32'd255);

    $display("[TB] lock timeout");
    n = 0;
    while (state_o !== 2'd1 && n < 10) begin
      applyStimulus(1'b0, 1'b0);
      n++;
    end
    checkOutput("timeout_enter_wait", 32'(state_o), 32'd1);
    for (int j = 0; j < LOCK_TIMEOUT_CYCLES - 1; j++) applyStimulus(1'b0, 1'b0);
    checkOutput("timeout_early", 32'(timeout_o), 32'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("timeout_set", 32'(timeout_o), 32'd1);
    errs = 0;
`ifdef PLL_RESET_SEQ_AUTORETRY_EN
    for (int s = 0; s < 48; s++) begin
      if (pll_rst_o !== ((s % (PLL_RST_CYCLES + LOCK_TIMEOUT_CYCLES)) < PLL_RST_CYCLES)) errs++;
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("timeout_retry_pulses", 32'(errs), 32'd0);
`else
    for (int s = 0; s < 48; s++) begin
      if (state_o !== 2'd1 || pll_rst_o !== 1'b0) errs++;
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("timeout_hold_wait", 32'(errs), 32'd0);
`endif
    runUntilReady("timeout_then_lock", 60);
    checkOutput("timeout_sticky", 32'(timeout_o), 32'd1);

    $display("[TB] randomized lock and sw reset");
    seg_left = 0;
    lk       = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (seg_left == 0) begin
        lk       = ($urandom_range(0, 3) != 0);
        seg_left = $urandom_range(1, 40);
      end
      seg_left--;
      applyStimulus(lk, $urandom_range(0, 63) == 0);
    end

    $display("[TB] async reset mid-STABLE");
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (state_o !== 2'd2 && n < 30) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("async_prep_stable", 32'(state_o), 32'd2);
    checkOutput("async_prep_loss", 32'(loss_cnt_o), 32'd255);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset", 32'(dutVec()), 32'({2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0}));
    #1 reset = 1'b0;
    modelReset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("after_async_ready", 32'(ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
